tdc_sequencer: RTL and testbench
================================

TDC_SEQUENCER -- requirements
Module: tdc_sequencer

Interface
REQ-001 Parameter STAGES, default 64: width of the thermometer word from the fine carry-chain TDC.
REQ-002 Parameter FINE_W, default 7: fine result width, at least clog2(STAGES+1).
REQ-003 Parameter COARSE_W, default 16: width of the coarse cycle counter.
REQ-004 Parameter TIMEOUT, default 1000: number of ARMED cycles without a hit before the measurement aborts.
REQ-005 Parameter CLR_CYCLES, default 3: length of the chain-clear pulse in cycles.
REQ-006 Port clock, input, 1 bit: the single clock; it is also the fine TDC STOP/sample clock.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port arm, input, 1 bit: single-cycle request to start one measurement.
REQ-009 Port thermo, input, STAGES bits: double-registered thermometer word from the fine TDC.
REQ-010 Port tdc_clear, output, 1 bit: drives the fine TDC register reset.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port res_valid, output, 1 bit; port res_ready, input, 1 bit: result handshake.
REQ-013 Port res_fine, output, FINE_W bits; port res_coarse, output, COARSE_W bits: measurement result.
REQ-014 Port res_timeout, output, 1 bit; port res_overflow, output, 1 bit: result status flags.

Function
REQ-015 The controller SHALL implement the states IDLE, CLEAR, ARMED, CAPTURE and HOLD.
REQ-016 IDLE: arm=1 SHALL move to CLEAR on the next edge; arm SHALL be ignored in every other state.
REQ-017 CLEAR: tdc_clear=1 for exactly CLR_CYCLES cycles, then ARMED; the coarse counter is set to 0 on entry.
REQ-018 ARMED: coarse counter +1 per cycle; the first cycle with thermo != 0 SHALL latch thermo and the counter value and move to CAPTURE.
REQ-019 ARMED: if the counter reaches TIMEOUT-1 with no hit, the block SHALL go to HOLD with res_timeout=1, res_fine=0, res_coarse=TIMEOUT-1.
REQ-020 A hit and the timeout in the same cycle: the hit SHALL win.
REQ-021 CAPTURE lasts one cycle: res_fine = population count of the latched word (bubble-tolerant); res_overflow=1 when all STAGES bits are 1. Then HOLD.
REQ-022 HOLD: res_valid=1 and res_* stable until res_valid and res_ready are both high; on that edge go to IDLE and drop res_valid.
REQ-023 arm in the same cycle as the HOLD handshake SHALL be ignored; the fastest re-arm is the cycle after the return to IDLE.
REQ-024 Latency, hit to res_valid: 2 cycles (ARMED latch, CAPTURE, HOLD). Latency, arm to first ARMED cycle: CLR_CYCLES+1.
REQ-025 The coarse counter SHALL saturate at all-ones and never wrap.
REQ-026 res_fine SHALL be the zero-extended count; the arithmetic SHALL be unsigned.

Reset
REQ-027 While reset=1, asynchronously: state=IDLE, tdc_clear=1, busy=0, res_valid=0, res_fine=0, res_coarse=0, res_timeout=0, res_overflow=0.
REQ-028 Reset asserted mid-measurement SHALL discard the measurement; after release, tdc_clear=0 and the block waits in IDLE for arm.

Structure
REQ-029 A shared package SHALL hold the state enumeration and the default constants (CLR_CYCLES, TIMEOUT).
REQ-030 The popcount SHALL be a separate combinational sub-module, thermo_popcount, parameterised by STAGES and FINE_W.
REQ-031 The fine TDC instance SHALL stay outside this block.

Verification
REQ-032 Scenario, normal hit: arm, then thermo=0x0000_0000_0000_001F in the 5th ARMED cycle -> res_fine=5, res_coarse=4, flags 0, res_valid 2 cycles later.
REQ-033 Scenario, timeout: arm, thermo held at 0 -> res_timeout=1, res_coarse=999, res_fine=0.
REQ-034 Scenario, bubble plus overflow: thermo=0x...0B gives res_fine=3; thermo all ones gives res_fine=64 with res_overflow=1.
REQ-035 Scenario, backpressure: res_ready low for 10 cycles -> res_* stable throughout; arm pulses during HOLD are ignored.
REQ-036 Scenario, reset during ARMED: assert reset -> all outputs at reset values immediately, with no res_valid afterwards.
REQ-037 Scenario, hit on the timeout cycle: thermo != 0 when the counter is 999 -> res_timeout=0 and res_fine is valid.

Source files
------------

// File: rtl/tdc_sequencer_pkg.sv
// Shared state encoding and default timing constants for the TDC measurement sequencer.
// No logic; no latency; no backpressure.
// Imported by the sequencer top and any block that decodes its state.
package tdc_sequencer_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_ARMED   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam int DEF_STAGES     = 64;
    localparam int DEF_FINE_W     = 7;
    localparam int DEF_COARSE_W   = 16;
    localparam int DEF_CLR_CYCLES = 3;
    localparam int DEF_TIMEOUT    = 1000;

endpackage

// File: rtl/thermo_popcount.sv
// Counts set bits in a thermometer word so that bubbles do not corrupt the fine code.
// Latency: combinational.
// Backpressure: none.
module thermo_popcount #(
    parameter int STAGES = 64,
    parameter int FINE_W = 7
) (
    input  logic [STAGES-1:0] word,
    output logic [FINE_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < STAGES; i++) begin
            count = count + FINE_W'(word[i]);
        end
    end

endmodule

// File: rtl/tdc_sequencer.sv
// Arms the fine TDC, counts coarse cycles until the first hit or timeout, and holds the result.
// Latency: arm to first armed cycle CLR_CYCLES+1; hit to res_valid 2 cycles.
// Backpressure: result held stable in HOLD until res_ready; arm ignored outside IDLE.
module tdc_sequencer #(
    parameter int STAGES     = tdc_sequencer_pkg::DEF_STAGES,
    parameter int FINE_W     = tdc_sequencer_pkg::DEF_FINE_W,
    parameter int COARSE_W   = tdc_sequencer_pkg::DEF_COARSE_W,
    parameter int TIMEOUT    = tdc_sequencer_pkg::DEF_TIMEOUT,
    parameter int CLR_CYCLES = tdc_sequencer_pkg::DEF_CLR_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                arm,
    input  logic [STAGES-1:0]   thermo,
    output logic                tdc_clear,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [FINE_W-1:0]   res_fine,
    output logic [COARSE_W-1:0] res_coarse,
    output logic                res_timeout,
    output logic                res_overflow
);

    import tdc_sequencer_pkg::*;

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
    localparam logic [CW-1:0]       CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [COARSE_W-1:0] TO_LAST  = COARSE_W'(TIMEOUT - 1);

    logic [2:0]          state;
    logic [CW-1:0]       clr_cnt;
    logic [COARSE_W-1:0] coarse;
    logic [STAGES-1:0]   word_q;
    logic [FINE_W-1:0]   pop;

    thermo_popcount #(
        .STAGES (STAGES),
        .FINE_W (FINE_W)
    ) u_popcount (
        .word  (word_q),
        .count (pop)
    );

    // Reset must hold the fine chain cleared without waiting for a clock edge.
    assign tdc_clear = reset | (state == ST_CLEAR);
    assign busy      = (state != ST_IDLE);
    assign res_valid = (state == ST_HOLD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            clr_cnt      <= '0;
            coarse       <= '0;
            word_q       <= '0;
            res_fine     <= '0;
            res_coarse   <= '0;
            res_timeout  <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        coarse  <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state <= ST_ARMED;
                    end else begin
                        clr_cnt <= clr_cnt + CW'(1);
                    end
                end
                ST_ARMED: begin
                    // A hit on the last armed cycle still wins over the timeout.
                    if (thermo != '0) begin
                        word_q     <= thermo;
                        res_coarse <= coarse;
                        state      <= ST_CAPTURE;
                    end else if (coarse == TO_LAST) begin
                        res_coarse   <= coarse;
                        res_fine     <= '0;
                        res_timeout  <= 1'b1;
                        res_overflow <= 1'b0;
                        state        <= ST_HOLD;
                    end else if (coarse != '1) begin
                        coarse <= coarse + COARSE_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    res_fine     <= pop;
                    res_overflow <= &word_q;
                    res_timeout  <= 1'b0;
                    state        <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed and randomized measurements against a result/timing model derived from the measurement rules.
module tb_tdc_sequencer;

    localparam int STAGES     = 64;
    localparam int FINE_W     = 7;
    localparam int COARSE_W   = 16;
    localparam int TIMEOUT    = 1000;
    localparam int CLR_CYCLES = 3;

    logic                clock;
    logic                reset;
    logic                arm;
    logic [STAGES-1:0]   thermo;
    logic                tdc_clear;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic [FINE_W-1:0]   res_fine;
    logic [COARSE_W-1:0] res_coarse;
    logic                res_timeout;
    logic                res_overflow;

    int checks = 0;
    int errors = 0;

    tdc_sequencer #(
        .STAGES     (STAGES),
        .FINE_W     (FINE_W),
        .COARSE_W   (COARSE_W),
        .TIMEOUT    (TIMEOUT),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .thermo       (thermo),
        .tdc_clear    (tdc_clear),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_fine     (res_fine),
        .res_coarse   (res_coarse),
        .res_timeout  (res_timeout),
        .res_overflow (res_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // k = armed cycle (0-based) in which the first non-zero word appears; k >= TIMEOUT means never.
    task automatic measure(input int k, input logic [63:0] w, input int stall);
        bit          hit;
        int          n;
        int          c;
        int          exp_n;
        logic [63:0] exp_fine;
        logic [63:0] exp_coarse;
        logic [63:0] exp_to;
        logic [63:0] exp_ov;

        hit        = (k >= 0) && (k < TIMEOUT);
        exp_fine   = hit ? 64'($countones(w)) : 64'd0;
        exp_coarse = hit ? 64'(k) : 64'(TIMEOUT - 1);
        exp_to     = hit ? 64'd0 : 64'd1;
        exp_ov     = (hit && (w == '1)) ? 64'd1 : 64'd0;
        exp_n      = hit ? k + 2 : TIMEOUT;

        check("idle_busy", 64'(busy), 64'd0);
        arm = 1'b1;
        tick;
        arm = 1'b0;
        c = 0;
        while (tdc_clear && c < 50) begin
            c++;
            tick;
        end
        check("clear_len", 64'(c), 64'(CLR_CYCLES));
        check("armed_busy", 64'(busy), 64'd1);

        n = 0;
        while (!res_valid && n < TIMEOUT + 10) begin
            if (n == k) thermo = w;
            else if (hit && n > k) thermo = rand64();
            else thermo = '0;
            tick;
            n++;
        end
        thermo = '0;
        check("valid_time", 64'(n), 64'(exp_n));
        check("res_fine", 64'(res_fine), exp_fine);
        check("res_coarse", 64'(res_coarse), exp_coarse);
        check("res_timeout", 64'(res_timeout), exp_to);
        check("res_overflow", 64'(res_overflow), exp_ov);

        for (int i = 0; i < stall; i++) begin
            arm = 1'($urandom_range(0, 1));
            tick;
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_fine", 64'(res_fine), exp_fine);
            check("hold_coarse", 64'(res_coarse), exp_coarse);
            check("hold_flags", {62'd0, res_timeout, res_overflow}, {62'd0, exp_to[0], exp_ov[0]});
        end

        // arm coinciding with the handshake must not restart a measurement
        res_ready = 1'b1;
        arm       = 1'b1;
        tick;
        res_ready = 1'b0;
        arm       = 1'b0;
        check("post_valid", 64'(res_valid), 64'd0);
        check("post_busy", 64'(busy), 64'd0);
        check("post_clear", 64'(tdc_clear), 64'd0);
        tick;
        check("post_busy2", 64'(busy), 64'd0);
    endtask

    initial begin
        int          vcnt;
        int          bcnt;
        logic [63:0] w;

        reset     = 1'b1;
        arm       = 1'b0;
        res_ready = 1'b0;
        thermo    = '0;
        #3;
        check("rst_clear", 64'(tdc_clear), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_res", {res_fine, res_coarse, res_timeout, res_overflow}, 64'd0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        check("rel_clear", 64'(tdc_clear), 64'd0);

        measure(4, 64'h0000_0000_0000_001F, 10);
        measure(TIMEOUT, 64'd0, 2);
        measure(int'($urandom_range(0, 30)), 64'h0000_0000_0000_000B, 1);
        measure(int'($urandom_range(0, 30)), '1, 3);
        measure(TIMEOUT - 1, 64'h0000_0000_0000_00FF, 0);
        measure(0, 64'h8000_0000_0000_0000, 1);

        for (int r = 0; r < 8; r++) begin
            w = rand64();
            if (w == 64'd0) w = 64'd1;
            measure(int'($urandom_range(0, 60)), w, int'($urandom_range(0, 6)));
        end

        // reset in the middle of an armed window discards the measurement
        arm = 1'b1;
        tick;
        arm = 1'b0;
        repeat (CLR_CYCLES + 5) tick;
        check("mid_busy", 64'(busy), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_clear", 64'(tdc_clear), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(res_valid), 64'd0);
        check("mid_rst_res", {res_fine, res_coarse, res_timeout, res_overflow}, 64'd0);
        tick;
        reset = 1'b0;
        #1;
        check("mid_rel_clear", 64'(tdc_clear), 64'd0);
        vcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            thermo = rand64() | 64'd1;
            tick;
            if (res_valid) vcnt++;
            if (busy) bcnt++;
        end
        thermo = '0;
        check("no_valid_after_rst", 64'(vcnt), 64'd0);
        check("idle_after_rst", 64'(bcnt), 64'd0);

        measure(2, 64'h0000_0000_0000_0007, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
